// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU behind a start/busy/done handshake.
// Keeps the legacy 3-bit ALU control encoding. It adds iterative SLL/SRL,
// which shift one bit per cycle, and MUL, which is shift-and-add.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           launch request, accepted only when idle
//   gin, a, b       op code and operands, captured with start
//   busy            high while an operation is in flight
//   done            one-cycle pulse when result/flags are valid
//   result          registered result, held until the next done
//   zout, nout, ovf zero / negative / signed-overflow flags, updated with done
//
// The visible outputs are registered one stage behind the control state.
// As a result, a single-cycle op raises done one edge after start, and an
// iterative op raises done one edge after its last iteration.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zout,
  output logic             nout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               ovf_p_q, ovf_p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zout_q, zout_d;
  logic               nout_q, nout_d;
  logic               ovf_q, ovf_d;

  // Single-cycle datapath, evaluated on the live operands at capture time
  logic [WIDTH-1:0] sum, diff;
  logic             ovf_add, ovf_sub, slt, shift_big, b_zero, accept;

  always_comb begin
    sum       = a + b;
    diff      = a + ~b + WIDTH'(1);
    ovf_add   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_sub   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Sign of a-b corrected by overflow gives the true signed compare
    slt       = diff[WIDTH-1] ^ ovf_sub;
    shift_big = |b[WIDTH-1:CNT_W];
    b_zero    = (b == '0);
    // busy_q still high while the state is idle marks the visible done cycle
    accept    = start && (state_q == S_IDLE) && !busy_q;
  end

  // Next-state, iteration and output-stage logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ovf_p_d  = ovf_p_q;
    result_d = result_q;
    zout_d   = zout_q;
    nout_d   = nout_q;
    ovf_d    = ovf_q;
    busy_d   = (state_q != S_IDLE);
    done_d   = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = gin;
          mcand_d  = a;
          mplier_d = b;
          ovf_p_d  = 1'b0;
          state_d  = S_DONE;
          case (gin)
            OP_ADD: begin
              acc_d   = sum;
              ovf_p_d = ovf_add;
            end
            OP_SUB: begin
              acc_d   = diff;
              ovf_p_d = ovf_sub;
            end
            OP_SLT: acc_d = {{(WIDTH-1){1'b0}}, slt};
            OP_AND: acc_d = a & b;
            OP_OR:  acc_d = a | b;
            OP_SLL, OP_SRL: begin
              // Out-of-range and zero shifts finish without iterating
              if (shift_big) begin
                acc_d = '0;
              end else if (b_zero) begin
                acc_d = a;
              end else begin
                acc_d   = a;
                cnt_d   = b[CNT_W-1:0] - CNT_W'(1);
                state_d = S_RUN;
              end
            end
            OP_MUL: begin
              acc_d   = '0;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = S_RUN;
            end
            default: acc_d = '0;
          endcase
        end
      end

      S_RUN: begin
        case (op_q)
          OP_SLL: acc_d = acc_q << 1;
          OP_SRL: acc_d = acc_q >> 1;
          OP_MUL: begin
            if (mplier_q[0]) begin
              acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          default: acc_d = acc_q;
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        result_d = acc_q;
        zout_d   = (acc_q == '0);
        nout_d   = acc_q[WIDTH-1];
        ovf_d    = ovf_p_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ovf_p_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zout_q   <= 1'b0;
      nout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ovf_p_q  <= ovf_p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zout_q   <= zout_d;
      nout_q   <= nout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zout   = zout_q;
  assign nout   = nout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed and random ops on 32-bit and 8-bit instances,
// checked against an arithmetic reference model.
module tb_alu_seq;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start32, start8;
  logic [2:0]  gin;
  logic [31:0] a, b;

  logic        busy32, done32, z32, n32, o32;
  logic [31:0] res32;
  logic        busy8, done8, z8, n8, o8;
  logic [7:0]  res8;

  int total = 0;
  int bad   = 0;
  int dcnt32 = 0;
  int dcnt8  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .gin(gin), .a(a), .b(b),
    .busy(busy32), .done(done32), .result(res32), .zout(z32), .nout(n32), .ovf(o32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .gin(gin), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .result(res8), .zout(z8), .nout(n8), .ovf(o8)
  );

  always @(posedge clk) begin
    if (done32) dcnt32 <= dcnt32 + 1;
    if (done8)  dcnt8  <= dcnt8 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: result, overflow and latency from the op definitions in width w
  function automatic void model(input int w, input logic [2:0] op,
                                input longint unsigned ai, input longint unsigned bi,
                                output longint unsigned r, output bit ov, output int lat);
    longint unsigned m, x, y;
    longint sa, sb;
    m   = (64'd1 << w) - 1;
    x   = ai & m;
    y   = bi & m;
    sa  = ((x >> (w - 1)) & 1) != 0 ? longint'(x) - (longint'(1) << w) : longint'(x);
    sb  = ((y >> (w - 1)) & 1) != 0 ? longint'(y) - (longint'(1) << w) : longint'(y);
    ov  = 1'b0;
    lat = 1;
    case (op)
      OP_ADD: begin r = (x + y) & m; ov = (sa + sb) != ((r >> (w-1)) != 0 ? longint'(r) - (longint'(1) << w) : longint'(r)); end
      OP_SUB: begin r = (x - y) & m; ov = (sa - sb) != ((r >> (w-1)) != 0 ? longint'(r) - (longint'(1) << w) : longint'(r)); end
      OP_SLT: r = (sa < sb) ? 1 : 0;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_SLL, OP_SRL: begin
        if (y >= longint'(w)) r = 0;
        else if (y == 0) r = x;
        else begin
          r   = (op == OP_SLL) ? ((x << y) & m) : (x >> y);
          lat = int'(y) + 1;
        end
      end
      OP_MUL: begin r = (x * y) & m; lat = w + 1; end
      default: r = 0;
    endcase
  endfunction

  task automatic set_start(input bit w8, input logic v);
    if (w8) start8 = v; else start32 = v;
  endtask

  // mode 0: plain; 1: extra start mid-RUN; 2: start held during the done cycle
  task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int mode, input string tag);
    longint unsigned er;
    bit eov;
    int elat, n, nb, d0, w;
    logic dn, bz;
    logic [31:0] rr;
    logic rz, rn, ro;
    w = w8 ? 8 : 32;
    model(w, op, longint'(av), longint'(bv), er, eov, elat);
    @(negedge clk);
    gin = op; a = av; b = bv;
    set_start(w8, 1'b1);
    d0 = w8 ? dcnt8 : dcnt32;
    @(posedge clk); #1;
    set_start(w8, 1'b0);
    n = 0; nb = 0; dn = 1'b0;
    while (!dn && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mode == 1 && n == 3) begin
        gin = OP_MUL; a = $urandom; b = $urandom; set_start(w8, 1'b1);
      end else if (mode == 1 && n == 4) begin
        set_start(w8, 1'b0);
      end
      dn = w8 ? done8 : done32;
      bz = w8 ? busy8 : busy32;
      if (bz) nb++;
    end
    rr = w8 ? {24'd0, res8} : res32;
    rz = w8 ? z8 : z32;
    rn = w8 ? n8 : n32;
    ro = w8 ? o8 : o32;
    chk({tag, ".lat"}, 64'(n), 64'(elat));
    chk({tag, ".busy_cycles"}, 64'(nb), 64'(elat));
    chk({tag, ".result"}, 64'(rr), er);
    chk({tag, ".zout"}, 64'(rz), 64'(er == 0));
    chk({tag, ".nout"}, 64'(rn), 64'((er >> (w - 1)) & 1));
    chk({tag, ".ovf"}, 64'(ro), 64'(eov));
    if (mode == 2) begin
      gin = OP_ADD; a = 32'd1; b = 32'd1; set_start(w8, 1'b1);
    end
    @(posedge clk); #1;
    set_start(w8, 1'b0);
    chk({tag, ".done_pulse"}, 64'(w8 ? done8 : done32), 64'd0);
    chk({tag, ".busy_end"}, 64'(w8 ? busy8 : busy32), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".done_count"}, 64'(w8 ? dcnt8 : dcnt32), 64'(d0 + 1));
  endtask

  initial begin
    int d_before;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bit rw8;

    // Reset held with start asserted
    rst_n = 1'b0; start32 = 1'b1; start8 = 1'b1; gin = OP_ADD; a = 32'd5; b = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy32), 64'd0);
    chk("rst.done", 64'(done32), 64'd0);
    chk("rst.result", 64'(res32), 64'd0);
    chk("rst.zout", 64'(z32), 64'd0);
    chk("rst.nout", 64'(n32), 64'd0);
    chk("rst.ovf", 64'(o32), 64'd0);
    chk("rst8.result", 64'(res8), 64'd0);
    rst_n = 1'b1; start32 = 1'b0; start8 = 1'b0;

    run_op(1'b0, OP_ADD, 32'd5, 32'd3, 0, "add5_3");
    run_op(1'b0, OP_SUB, 32'd3, 32'd3, 0, "sub_zero");
    run_op(1'b0, OP_SUB, 32'h8000_0000, 32'd1, 0, "sub_ovf");
    run_op(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf");
    run_op(1'b0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
    run_op(1'b0, OP_SLT, 32'h8000_0000, 32'd1, 0, "slt_ovfc");
    run_op(1'b0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, "and");
    run_op(1'b0, OP_OR,  32'hF000_0000, 32'h0000_000F, 0, "or");
    run_op(1'b0, OP_SLL, 32'd1, 32'd4, 0, "sll4");
    run_op(1'b0, OP_SLL, 32'd1, 32'd0, 0, "sll0");
    run_op(1'b0, OP_SLL, 32'd1, 32'd32, 0, "sll32");
    run_op(1'b0, OP_SRL, 32'h8000_0000, 32'd31, 0, "srl31");
    run_op(1'b0, OP_SRL, 32'h1234_5678, 32'h0001_0000, 0, "srl_big");
    run_op(1'b0, OP_MUL, 32'd7, 32'd6, 1, "mul7_6");
    run_op(1'b0, OP_MUL, 32'hFFFF_FFFF, 32'd2, 1, "mul_wrap");
    run_op(1'b0, OP_MUL, 32'd123, 32'd0, 0, "mul_b0");
    run_op(1'b0, OP_ADD, 32'd9, 32'd9, 2, "start_in_done");

    // Abort a MUL with reset part way through
    @(negedge clk);
    gin = OP_MUL; a = 32'd7; b = 32'd6; start32 = 1'b1;
    d_before = dcnt32;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort.busy", 64'(busy32), 64'd0);
    chk("abort.done", 64'(done32), 64'd0);
    chk("abort.result", 64'(res32), 64'd0);
    chk("abort.flags", 64'({z32, n32, o32}), 64'd0);
    chk("abort.no_done", 64'(dcnt32), 64'(d_before));
    run_op(1'b0, OP_ADD, 32'd1, 32'd1, 0, "abort_add");

    // Narrow instance
    run_op(1'b1, OP_MUL, 32'd16, 32'd16, 0, "w8_mul");
    run_op(1'b1, OP_SLL, 32'd1, 32'd7, 0, "w8_sll7");
    run_op(1'b1, OP_SLL, 32'd1, 32'd8, 0, "w8_sll8");
    run_op(1'b1, OP_ADD, 32'd127, 32'd1, 0, "w8_add_ovf");

    // Random mix across both widths, including unused codes
    for (int i = 0; i < 40; i++) begin
      rw8 = ($urandom_range(0, 3) == 0);
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (rop == OP_SLL || rop == OP_SRL) begin
        if ($urandom_range(0, 4) != 0) rb = rw8 ? $urandom_range(0, 9) : $urandom_range(0, 34);
      end
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(rw8, rop, ra, rb, 0, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle combinational ALU in the datapath.
- Keeps the existing 3-bit ALU control encoding and adds three iterative operations: logical right shift, variable left shift and multiply.
- All results are registered behind a start/busy/done handshake.
- Sits between the register-file read ports and the writeback mux. The control FSM stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of two, minimum 8.
- CNT_W, derived as log2(WIDTH), width of the internal iteration counter. Not overridable.

Ports:
- clk  in  1  single clock. All state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  launch request. Sampled only in IDLE.
- gin  in  3  ALU control line. Captured with start.
- a  in  WIDTH  operand A. Captured with start.
- b  in  WIDTH  operand B. Captured with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  registered result. Held until the next done.
- zout  out  1  high when result is all zeros. Updated with done.
- nout  out  1  equals result[WIDTH-1]. Updated with done.
- ovf  out  1  signed overflow for ADD/SUB. 0 for every other op. Updated with done.

Behaviour:
- Reset: applies only on a clk edge with rst_n=0. State goes to IDLE; busy, done, result, zout, nout and ovf all go to 0; the counter clears.
- Reset mid-operation aborts the operation. No done is produced.
- States:
  - IDLE: start=1 captures a, b and gin. Single-cycle ops go to DONE. Iterative ops go to RUN.
  - RUN: performs one iteration per cycle. Goes to DONE when the counter reaches its terminal value.
  - DONE: done=1 for exactly this one cycle; result and flags are written on entry. Next state is IDLE unconditionally.
- busy=1 in RUN and DONE.
- start while busy=1 is ignored; there is no queueing. start asserted in the DONE cycle is also ignored.
- Latency L is measured from the start edge to the edge that raises done.
- Single-cycle ops, L=1:
  - 010 ADD: a+b.
  - 110 SUB: a+~b+1.
  - 111 SLT: 1 if (a-b) is negative as a signed value (true signed compare, overflow-corrected), else 0.
  - 000 AND.
  - 001 OR.
- 011 SLL: a shifted left by b, one bit per RUN cycle.
  - If b >= WIDTH (any upper bit set): result=0 with L=1, no RUN.
  - If b=0: result=a with L=1.
  - Otherwise L = b+1.
- 100 SRL: logical right shift, zero fill. Same latency and boundary rules as SLL.
- 101 MUL: unsigned shift-and-add, lower WIDTH bits of a*b kept, upper bits discarded.
  - Always WIDTH RUN iterations, so L = WIDTH+1.
  - No early exit on b=0.
- Unused codes: result=0 with L=1. (The codebase's default of x is not acceptable in registered logic.)
- ovf:
  - ADD: operands of equal sign and the sum's sign differs.
  - SUB: operand signs differ and the result's sign differs from a.
- Outputs are stable between done pulses. Operand changes during RUN have no effect.
- WIDTH changes only the datapath and counter widths. The op encoding does not change.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 and gin=010 -> busy=0, done=0, result=0, zout=0, ovf=0. Then rst_n=1, a=5, b=3, start for 1 cycle -> done one cycle later, result=8, zout=0, nout=0, ovf=0.
- SUB/SLT/flags, WIDTH=32:
  - SUB a=3, b=3 -> result=0, zout=1.
  - SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1.
  - SLT a=0xFFFFFFFF, b=1 -> result=1.
  - SLT a=0x80000000, b=1 -> result=1 (overflow-corrected).
- SLL a=1, b=4 -> busy for 5 cycles, done at L=5, result=16. Then:
  - SLL b=0 -> L=1, result=1.
  - SLL b=32 -> L=1, result=0, zout=1.
  - SRL a=0x80000000, b=31 -> L=32, result=1.
- MUL a=7, b=6 -> done at exactly 33 cycles, result=42.
  - MUL a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE.
  - start pulsed mid-RUN with different operands -> ignored; result still 42/0xFFFFFFFE and only one done.
- Abort: start MUL, drop rst_n at cycle 10 for 1 cycle -> no done, all outputs 0, IDLE. A new ADD a=1, b=1 issued the next cycle completes with result=2.
- Parameter: WIDTH=8, MUL a=16, b=16 -> L=9, result=0, zout=1. SLL a=1, b=7 -> result=0x80, nout=1.
